// File: rtl/ioctl_sdram_loader_if.sv
// SDRAM write port of the ROM download pump.
// Toggle handshake: a new request is pending while req differs from ack.
interface ioctl_sdram_loader_if #(
    parameter int ADDR_W = 23,
    parameter int DATA_W = 16
);
    logic                  req;
    logic                  ack;
    logic                  we;
    logic [ADDR_W-1:0]     a;
    logic [DATA_W/8-1:0]   ds;
    logic [DATA_W-1:0]     d;

    modport master (output req, we, a, ds, d, input ack);
    modport slave  (input req, we, a, ds, d, output ack);
endinterface

// File: rtl/ioctl_sdram_loader.sv
// ROM download pump: data_io bytes -> packed words -> FIFO -> SDRAM.
// Optional byte checksum enabled by defining LOADER_CHECKSUM_EN.
module ioctl_sdram_loader #(
    parameter int         DATA_W     = 16,
    parameter int         ADDR_W     = 23,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] ROM_INDEX  = 8'd0,
    parameter int         HOLD_CYC   = 16
) (
    input  logic        clk_sys,
    input  logic        res_n_i,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    ioctl_sdram_loader_if.master sdram,
    output logic        rom_loaded,
    output logic        core_reset,
    output logic        busy,
    output logic        overflow,
    output logic [15:0] checksum
);
    localparam int BYTES = DATA_W / 8;
    localparam int LB    = $clog2(BYTES);
    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int CW    = $clog2(HOLD_CYC + 1);

    typedef enum logic {S_IDLE, S_WAIT} iss_t;
    typedef enum logic [1:0] {C_LOAD, C_DRAIN, C_HOLD, C_DONE} cmp_t;

    logic wr_q, mine_q;
    logic mine, start, fall, accept;
    logic [LB-1:0]     lane;
    logic [ADDR_W-1:0] waddr;
    logic unused_bits;

    assign mine   = ioctl_download && (ioctl_index == ROM_INDEX);
    assign start  = mine && !mine_q;
    assign fall   = !mine && mine_q;
    assign accept = mine && ioctl_wr && !wr_q;
    assign lane   = ioctl_addr[LB-1:0];
    assign waddr  = ioctl_addr[ADDR_W+LB-1:LB];
    assign unused_bits = ^ioctl_addr;

    // Edge detectors for the byte strobe and the accepted-download level
    always_ff @(posedge clk_sys) begin
        if (!res_n_i) begin
            wr_q   <= 1'b0;
            mine_q <= 1'b0;
        end else begin
            wr_q   <= ioctl_wr;
            mine_q <= mine;
        end
    end

    logic [ADDR_W-1:0] pk_addr, nx_a, push_a;
    logic [DATA_W-1:0] pk_data, nx_d, push_d, base_d;
    logic [BYTES-1:0]  pk_mask, nx_m, push_m, base_m;
    logic              push_v;

    // Packer next-state: merge, restart on new word, push when full or flushed
    always_comb begin
        base_m = start ? '0 : pk_mask;
        base_d = start ? '0 : pk_data;
        push_v = 1'b0;
        push_a = pk_addr;
        push_d = pk_data;
        push_m = pk_mask;
        nx_a   = pk_addr;
        nx_m   = base_m;
        nx_d   = base_d;
        if (accept) begin
            if (base_m != '0 && waddr != pk_addr) begin
                push_v = 1'b1;
                nx_m   = '0;
                nx_d   = '0;
            end
            nx_a = waddr;
            for (int i = 0; i < BYTES; i++) begin
                if (lane == LB'(i)) begin
                    nx_m[i]       = 1'b1;
                    nx_d[8*i +: 8] = ioctl_dout;
                end
            end
            if (&nx_m) begin
                push_v = 1'b1;
                push_a = waddr;
                push_d = nx_d;
                push_m = nx_m;
                nx_m   = '0;
                nx_d   = '0;
            end
        end else if (fall && pk_mask != '0) begin
            push_v = 1'b1;
            nx_m   = '0;
            nx_d   = '0;
        end
    end

    // Packer registers
    always_ff @(posedge clk_sys) begin
        if (!res_n_i) begin
            pk_addr <= '0;
            pk_data <= '0;
            pk_mask <= '0;
        end else begin
            pk_addr <= nx_a;
            pk_data <= nx_d;
            pk_mask <= nx_m;
        end
    end

    logic [ADDR_W-1:0] f_a [FIFO_DEPTH];
    logic [DATA_W-1:0] f_d [FIFO_DEPTH];
    logic [BYTES-1:0]  f_m [FIFO_DEPTH];
    logic [PW:0]       wp, rp;
    logic              empty, full, pop, do_push;
    iss_t              iss;

    assign empty   = (wp == rp);
    assign full    = (wp[PW] != rp[PW]) && (wp[PW-1:0] == rp[PW-1:0]);
    assign pop     = (iss == S_IDLE) && !empty;
    assign do_push = push_v && (!full || pop);

    // FIFO storage; a push into a full FIFO reuses the slot being popped
    always_ff @(posedge clk_sys) begin
        if (do_push) begin
            f_a[wp[PW-1:0]] <= push_a;
            f_d[wp[PW-1:0]] <= push_d;
            f_m[wp[PW-1:0]] <= push_m;
        end
    end

    // FIFO pointers and sticky overflow flag
    always_ff @(posedge clk_sys) begin
        if (!res_n_i) begin
            wp       <= '0;
            rp       <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push)
                wp <= wp + 1'b1;
            if (pop)
                rp <= rp + 1'b1;
            if (start)
                overflow <= 1'b0;
            else if (push_v && full && !pop)
                overflow <= 1'b1;
        end
    end

    logic              req_r, we_r;
    logic [ADDR_W-1:0] a_r;
    logic [BYTES-1:0]  ds_r;
    logic [DATA_W-1:0] d_r;

    assign sdram.req = req_r;
    assign sdram.we  = we_r;
    assign sdram.a   = a_r;
    assign sdram.ds  = ds_r;
    assign sdram.d   = d_r;

    // Issue FSM: one outstanding toggle request at a time
    always_ff @(posedge clk_sys) begin
        if (!res_n_i) begin
            iss   <= S_IDLE;
            req_r <= 1'b0;
            we_r  <= 1'b0;
            a_r   <= '0;
            ds_r  <= '0;
            d_r   <= '0;
        end else begin
            unique case (iss)
                S_IDLE: if (!empty) begin
                    a_r   <= f_a[rp[PW-1:0]];
                    ds_r  <= f_m[rp[PW-1:0]];
                    d_r   <= f_d[rp[PW-1:0]];
                    req_r <= ~req_r;
                    we_r  <= 1'b1;
                    iss   <= S_WAIT;
                end
                S_WAIT: if (sdram.ack == req_r) begin
                    we_r <= 1'b0;
                    iss  <= S_IDLE;
                end
            endcase
        end
    end

    cmp_t          cst;
    logic [CW-1:0] hcnt;

    // Completion FSM: hold the core in reset until the image is in SDRAM
    always_ff @(posedge clk_sys) begin
        if (!res_n_i) begin
            cst        <= C_LOAD;
            hcnt       <= '0;
            rom_loaded <= 1'b0;
            core_reset <= 1'b1;
        end else if (start) begin
            cst        <= C_LOAD;
            hcnt       <= '0;
            rom_loaded <= 1'b0;
            core_reset <= 1'b1;
        end else begin
            unique case (cst)
                C_LOAD: if (fall) cst <= C_DRAIN;
                C_DRAIN: if (pk_mask == '0 && empty && iss == S_IDLE) begin
                    cst  <= C_HOLD;
                    hcnt <= '0;
                end
                C_HOLD: if (hcnt == CW'(HOLD_CYC - 1)) begin
                    cst        <= C_DONE;
                    rom_loaded <= 1'b1;
                    core_reset <= 1'b0;
                end else begin
                    hcnt <= hcnt + 1'b1;
                end
                C_DONE: ;
            endcase
        end
    end

    assign busy = mine_q || (pk_mask != '0) || !empty || (iss == S_WAIT);

`ifdef LOADER_CHECKSUM_EN
    logic [15:0] sum_q;

    // Running byte sum, restarted by each accepted download
    always_ff @(posedge clk_sys) begin
        if (!res_n_i)
            sum_q <= '0;
        else if (start)
            sum_q <= accept ? 16'(ioctl_dout) : 16'h0000;
        else if (accept)
            sum_q <= sum_q + 16'(ioctl_dout);
    end

    assign checksum = sum_q;
`else
    assign checksum = 16'h0000;
`endif

endmodule
